// File: rtl/delay_pkg.sv
// delay_pkg: shared defaults, buffer depth and fill-FSM state encodings for the delay line
package delay_pkg;
  localparam int DEF_N = 4;
  localparam int DEF_DL = 4;
  localparam int DEPTH = 2**DEF_DL;
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;
endpackage

// File: rtl/delay_line_if.sv
// delay_line_if: sample/delay-control bundle; master drives in_valid/din/delay_load/delay_sel, slave returns dout/out_valid/busy/cur_delay
interface delay_line_if import delay_pkg::*; #(parameter int N = DEF_N, parameter int DL = DEF_DL);
  logic in_valid;
  logic [2**N-1:0] din;
  logic delay_load;
  logic [DL-1:0] delay_sel;
  logic [2**N-1:0] dout;
  logic out_valid;
  logic busy;
  logic [DL-1:0] cur_delay;
  modport master (output in_valid, din, delay_load, delay_sel, input dout, out_valid, busy, cur_delay);
  modport slave (input in_valid, din, delay_load, delay_sel, output dout, out_valid, busy, cur_delay);
endinterface

// File: rtl/delay_ram.sv
// delay_ram: 2**AW x W register file, one sync write port (clk/we/wa/wd), one async read port (ra/rd), no reset
module delay_ram #(parameter int W = 16, parameter int AW = 4) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/delay_line.sv
// delay_line: sample-counted programmable delay; clk, rst (async active-low), bus (delay_line_if.slave)
module delay_line import delay_pkg::*; #(parameter int N = DEF_N, parameter int DL = DEF_DL) (
  input logic clk,
  input logic rst,
  delay_line_if.slave bus
);
  localparam int W = 2**N;
  logic [DL-1:0] wr_ptr, d, fill_cnt, d_next, cnt_base, rd_addr;
  logic [0:0] state, st_base;
  logic [W-1:0] rd_data, dout_r;
  logic out_valid_r, emit;
  assign d_next = bus.delay_load ? bus.delay_sel : d;
  assign cnt_base = bus.delay_load ? '0 : fill_cnt;
  assign st_base = bus.delay_load ? (bus.delay_sel != '0 ? ST_FILL : ST_RUN) : state;
  assign rd_addr = wr_ptr - d_next;
  assign emit = st_base == ST_RUN || cnt_base == d_next;
  delay_ram #(.W(W), .AW(DL)) u_ram (
    .clk(clk), .we(bus.in_valid), .wa(wr_ptr), .wd(bus.din), .ra(rd_addr), .rd(rd_data)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      d <= '0;
      fill_cnt <= '0;
      state <= ST_RUN;
      dout_r <= '0;
      out_valid_r <= 1'b0;
    end else begin
      d <= d_next;
      out_valid_r <= bus.in_valid && emit;
      state <= bus.in_valid && emit ? ST_RUN : st_base;
      fill_cnt <= bus.in_valid && !emit ? cnt_base + DL'(1) : cnt_base;
      if (bus.in_valid) wr_ptr <= wr_ptr + DL'(1);
      if (bus.in_valid && emit) dout_r <= d_next == '0 ? bus.din : rd_data;
    end
  assign bus.dout = dout_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy = state == ST_FILL;
  assign bus.cur_delay = d;
endmodule
